// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, SRAM responder FSM states and the byte-lane strobe helper.
package ahb_pkg;

    localparam int unsigned HTRANS_W = 2;
    localparam int unsigned HRESP_W  = 2;
    localparam int unsigned HSIZE_W  = 3;
    localparam int unsigned STRB_W   = 4;

    typedef enum logic [HTRANS_W-1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [HRESP_W-1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [HSIZE_W-1:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    // Little-endian byte lanes touched by a transfer; illegal sizes touch nothing.
    function automatic logic [STRB_W-1:0] lane_strobe(input logic [HSIZE_W-1:0] size,
                                                      input logic [1:0]         addr);
        logic [STRB_W-1:0] strb;
        strb = '0;
        case (size)
            HSIZE_BYTE: strb = 4'(4'b0001 << addr);
            HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signals seen by one responder slot, with master and slave views.
interface ahb_sram_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    import ahb_pkg::*;

    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [HTRANS_W-1:0]   HTRANS;
    logic                  HWRITE;
    logic [HSIZE_W-1:0]    HSIZE;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic [HRESP_W-1:0]    HRESP;
    logic                  HREADYOUT;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HRESP, HREADYOUT
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HRESP, HREADYOUT
    );

endinterface

// File: rtl/ahb_slv_mem.sv
// Word array for the SRAM responder: byte-strobed synchronous write, asynchronous read.
module ahb_slv_mem #(
    parameter  int unsigned MEM_DEPTH = 256,
    localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic          HCLK,
    input  logic          i_we,
    input  logic [3:0]    i_strb,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    localparam int unsigned BYTE_LANES = 4;

    logic [31:0] r_mem [MEM_DEPTH];

    always_ff @(posedge HCLK) begin
        if (i_we) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (i_strb[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states and a two-cycle ERROR response.
// Build macro AHB_SLV_RO_REGION_EN makes words 0..RO_WORDS-1 read-only.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned OFFSET_BITS = 12,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned RO_WORDS    = 16
) (
    input logic              HCLK,
    input logic              HRESETn,
    ahb_sram_slave_if.slave  bus
);

    localparam int unsigned AW        = $clog2(MEM_DEPTH);
    localparam int unsigned MEM_BYTES = MEM_DEPTH * 4;
    localparam int unsigned CNT_W     = 4;

    slv_state_e              r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_wait_cnt, w_cnt_nxt;
    logic                    r_hreadyout, w_hreadyout_nxt;
    logic [HRESP_W-1:0]      r_hresp, w_hresp_nxt;
    logic                    r_write;
    logic [STRB_W-1:0]       r_strb;
    logic [AW-1:0]           r_word;
    logic                    w_accept, w_load, w_err, w_we, w_unused;
    logic [OFFSET_BITS-1:0]  w_offset;
    logic [DATA_WIDTH-1:0]   w_rdata;

    assign w_offset = bus.HADDR[OFFSET_BITS-1:0];
    assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    // Legality of the transfer currently in its address phase
    always_comb begin
        w_err = 1'b0;
        if (32'(w_offset) >= MEM_BYTES) w_err = 1'b1;
        if (bus.HSIZE > HSIZE_WORD) w_err = 1'b1;
        if ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0]) w_err = 1'b1;
        if ((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00)) w_err = 1'b1;
`ifdef AHB_SLV_RO_REGION_EN
        if (bus.HWRITE && (32'(w_offset[OFFSET_BITS-1:2]) < RO_WORDS)) w_err = 1'b1;
`endif
    end

`ifdef AHB_SLV_RO_REGION_EN
    assign w_unused = ^{bus.HADDR[ADDR_WIDTH-1:OFFSET_BITS], bus.HTRANS[0]};
`else
    assign w_unused = ^{bus.HADDR[ADDR_WIDTH-1:OFFSET_BITS], bus.HTRANS[0], 32'(RO_WORDS)};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        w_load      = 1'b0;
        unique case (r_state)
            ST_WAIT: begin
                w_cnt_nxt = r_wait_cnt - 4'd1;
                if (r_wait_cnt == 4'd1) w_state_nxt = ST_ACCESS;
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: begin
                // IDLE, ACCESS and ERR2 can all take a new transfer
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    w_load = 1'b1;
                    if (w_err) begin
                        w_state_nxt = ST_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES);
                    end else begin
                        w_state_nxt = ST_ACCESS;
                    end
                end
            end
        endcase
        w_hreadyout_nxt = !((w_state_nxt == ST_WAIT) || (w_state_nxt == ST_ERR1));
        w_hresp_nxt     = ((w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2)) ? HRESP_ERROR
                                                                                   : HRESP_OKAY;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_cnt_nxt;
            r_hreadyout <= w_hreadyout_nxt;
            r_hresp     <= w_hresp_nxt;
        end
    end

    // Address-phase capture for the upcoming data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_write <= 1'b0;
            r_strb  <= '0;
            r_word  <= '0;
        end else if (w_load) begin
            r_write <= bus.HWRITE;
            r_strb  <= lane_strobe(bus.HSIZE, bus.HADDR[1:0]);
            r_word  <= w_offset[AW+1:2];
        end
    end

    assign w_we = (r_state == ST_ACCESS) && r_write;

    ahb_slv_mem #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
        .HCLK    (HCLK),
        .i_we    (w_we),
        .i_strb  (r_strb),
        .i_addr  (r_word),
        .i_wdata (bus.HWDATA),
        .o_rdata (w_rdata)
    );

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;
    assign bus.HRDATA    = ((r_state == ST_ACCESS) && !r_write) ? w_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized AHB-Lite bench for ahb_sram_slave: byte-array reference model plus scoreboard monitor.
module tb_ahb_sram_slave;

    localparam int unsigned WS        = 2;
    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned MEM_BYTES = MEM_DEPTH * 4;
    localparam int unsigned RO_WORDS  = 16;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        logic [31:0] mask;
        int unsigned waits;
    } exp_t;

    logic HCLK      = 1'b0;
    logic HRESETn   = 1'b0;
    logic force_low = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    exp_t        exp_q[$];
    bit [7:0]    m_mem   [MEM_BYTES];
    bit          m_known [MEM_BYTES];

    ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ahb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .OFFSET_BITS(12),
        .MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(WS), .RO_WORDS(RO_WORDS)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    // Single responder on the bus, except when another slave holds HREADY low
    assign bus.HREADY = force_low ? 1'b0 : bus.HREADYOUT;

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: byte-addressed memory with per-byte knowledge tracking
    task automatic predict(input bit wr, input logic [11:0] a, input logic [2:0] sz,
                           input logic [31:0] wd, output exp_t e);
        int unsigned ai, nb, wb;
        ai     = 32'(a);
        e.rd   = !wr;
        e.data = '0;
        e.mask = '1;
        e.err  = (ai >= MEM_BYTES) || (sz > 3'd2) ||
                 ((sz == 3'd1) && (ai % 2 != 0)) || ((sz == 3'd2) && (ai % 4 != 0));
`ifdef AHB_SLV_RO_REGION_EN
        if (wr && (ai / 4 < RO_WORDS)) e.err = 1'b1;
`endif
        e.waits = e.err ? 32'd1 : WS;
        if (!e.err) begin
            nb = 32'd1 << sz;
            if (wr) begin
                for (int unsigned i = 0; i < nb; i++) begin
                    m_mem[ai+i]   = wd[8*((ai+i)%4) +: 8];
                    m_known[ai+i] = 1'b1;
                end
            end else begin
                wb     = ai - ai % 4;
                e.mask = '0;
                for (int i = 0; i < 4; i++) begin
                    e.data[8*i +: 8] = m_mem[wb+32'(i)];
                    e.mask[8*i +: 8] = m_known[wb+32'(i)] ? 8'hFF : 8'h00;
                end
            end
        end
    endtask

    task automatic drive_addr(input bit wr, input logic [11:0] a, input logic [2:0] sz);
        bus.HSEL   = 1'b1;
        bus.HADDR  = {20'($urandom), a};
        bus.HTRANS = 2'b10;
        bus.HWRITE = wr;
        bus.HSIZE  = sz;
    endtask

    task automatic wait_accept();
        bit rdy;
        int n;
        n = 0;
        do begin
            @(negedge HCLK);
            rdy = bus.HREADY;
            @(posedge HCLK);
            #1;
            n++;
            if (n > 100) begin
                n_errors++;
                $display("FAIL accept_timeout: no HREADY within %0d cycles", n);
                finish_run();
            end
        end while (!rdy);
    endtask

    task automatic issue(input bit wr, input logic [11:0] a, input logic [2:0] sz,
                         input logic [31:0] wd);
        exp_t e;
        predict(wr, a, sz, wd, e);
        exp_q.push_back(e);
        drive_addr(wr, a, sz);
        wait_accept();
        bus.HWDATA = wd;
    endtask

    task automatic idle_kind(input int k);
        case (k)
            0:       begin bus.HSEL = 1'b1; bus.HTRANS = 2'b00; end
            1:       begin bus.HSEL = 1'b1; bus.HTRANS = 2'b01; end
            default: begin bus.HSEL = 1'b0; bus.HTRANS = 2'b10; bus.HADDR = $urandom; end
        endcase
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    // Monitor: tracks data phases from bus activity and checks every cycle
    initial begin : monitor
        exp_t e;
        bit   active;
        int   n_low;
        active = 1'b0;
        n_low  = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                active = 1'b0;
                n_low  = 0;
                exp_q.delete();
                chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
                chk("rst_hresp",     32'(bus.HRESP),     32'd0);
                chk("rst_hrdata",    bus.HRDATA,         32'd0);
            end else begin
                if (active) begin
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL scoreboard_empty: data phase with no expected entry");
                        finish_run();
                    end
                    e = exp_q[0];
                    if (!bus.HREADYOUT) begin
                        n_low++;
                        chk("wait_hresp",  32'(bus.HRESP), e.err ? 32'd1 : 32'd0);
                        chk("wait_hrdata", bus.HRDATA, 32'd0);
                        if (n_low > 40) begin
                            n_errors++;
                            $display("FAIL ready_timeout: HREADYOUT low %0d cycles", n_low);
                            finish_run();
                        end
                    end else begin
                        void'(exp_q.pop_front());
                        chk("wait_count", 32'(n_low), e.waits);
                        chk("hresp", 32'(bus.HRESP), e.err ? 32'd1 : 32'd0);
                        chk("hrdata", bus.HRDATA & e.mask, e.data & e.mask);
                        active = 1'b0;
                        n_low  = 0;
                    end
                end else begin
                    chk("idle_hreadyout", 32'(bus.HREADYOUT), 32'd1);
                    chk("idle_hresp",     32'(bus.HRESP),     32'd0);
                    chk("idle_hrdata",    bus.HRDATA,         32'd0);
                end
                if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) active = 1'b1;
            end
        end
    end

    initial begin : stimulus
        exp_t        ph;
        bit          wr;
        logic [2:0]  sz;
        logic [11:0] a;

        bus.HSEL   = 1'b0;
        bus.HADDR  = '0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b010;
        bus.HWDATA = '0;
        HRESETn    = 1'b0;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        idle(2);

        for (int w = 0; w < int'(MEM_DEPTH); w++) issue(1'b1, 12'(w * 4), 3'b010, $urandom);
        idle(2);

        issue(1'b1, 12'h010, 3'b010, 32'hDEADBEEF);
        issue(1'b0, 12'h010, 3'b010, 32'h0);
        idle(2);

        issue(1'b1, 12'h020, 3'b010, 32'h11223344);
        issue(1'b1, 12'h021, 3'b000, 32'h5566AA77);
        issue(1'b0, 12'h020, 3'b010, 32'h0);
        idle(2);

        issue(1'b0, 12'h400, 3'b010, 32'h0);
        idle(2);

        issue(1'b1, 12'h003, 3'b001, 32'hCAFEBABE);
        issue(1'b1, 12'h020, 3'b011, 32'h87654321);
        issue(1'b0, 12'h020, 3'b010, 32'h0);
        issue(1'b0, 12'h000, 3'b010, 32'h0);
        idle(2);

        issue(1'b1, 12'h004, 3'b010, 32'hA5A5A5A5);
        issue(1'b0, 12'h004, 3'b010, 32'h0);
        issue(1'b1, 12'h040, 3'b010, 32'h5A5A5A5A);
        issue(1'b0, 12'h040, 3'b010, 32'h0);
        idle(2);

        // Another slave stalls the bus while this slot sits idle
        force_low = 1'b1;
        fork
            begin
                repeat (3) @(posedge HCLK);
                #1 force_low = 1'b0;
            end
        join_none
        issue(1'b0, 12'h084, 3'b010, 32'h0);
        idle(2);

        // Reset in the middle of a write's wait states; the write must be lost
        ph = '{err: 1'b0, rd: 1'b0, data: 32'h0, mask: 32'hFFFFFFFF, waits: WS};
        exp_q.push_back(ph);
        drive_addr(1'b1, 12'h080, 3'b010);
        wait_accept();
        bus.HWDATA = 32'h12345678;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        @(negedge HCLK);
        #1 HRESETn = 1'b0;
        #1;
        chk("async_rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("async_rst_hresp",     32'(bus.HRESP),     32'd0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        idle(1);
        issue(1'b0, 12'h080, 3'b010, 32'h0);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) idle_kind(int'($urandom_range(0, 2)));
            wr = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = 12'($urandom_range(0, MEM_BYTES - 1));
            if ($urandom_range(0, 9) != 0) begin
                case (sz)
                    3'd1:    a = a & 12'hFFE;
                    3'd2:    a = a & 12'hFFC;
                    default: a = a;
                endcase
            end
            if ($urandom_range(0, 19) == 0) a = 12'($urandom_range(MEM_BYTES, 4095));
            issue(wr, a, sz, $urandom);
        end

        idle(1);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) idle(1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d transfers still pending, expected 0", exp_q.size());
        end
        idle(2);
        finish_run();
    end

endmodule
